// File: rtl/uart_tx_queue_ctrl_pkg.sv
// Shared definitions for the UART TX ring-buffer drain controller:
// FSM states, default queue size and the memory-map addresses software uses.
package uart_tx_queue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int QUEUE_BYTES_DEFAULT = 256;

    localparam logic [31:0] TX_BUFFER_BASE = 32'hff00_0000;
    localparam logic [31:0] TX_QUEUE_TAIL  = 32'hff00_0100;
    localparam logic [31:0] TX_QUEUE_HEAD  = 32'hff00_0104;

    // Little-endian byte lane pick from a 32-bit buffer word.
    function automatic logic [7:0] select_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_queue_ctrl.sv
// Drains bytes from a word-organised TX ring buffer into a UART transmitter,
// one byte per IDLE -> LOAD -> SEND pass, advancing the consumer head on handshake.
module uart_tx_queue_ctrl
    import uart_tx_queue_ctrl_pkg::*;
#(
    parameter int QUEUE_BYTES = QUEUE_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] queue_tail,
    output logic [31:0] queue_head,
    output logic [5:0]  buf_addr,
    input  logic [31:0] buf_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy
);

    localparam logic [7:0] HEAD_MASK = 8'(QUEUE_BYTES - 1);

    state_t     state_reg, state_next;
    logic [7:0] head_reg, head_next;
    logic       tx_valid_reg, tx_valid_next;
    logic [7:0] tx_data_reg, tx_data_next;
    logic       unused_tail_bits;

    // Only the low byte of the producer index is meaningful.
    assign unused_tail_bits = ^queue_tail[31:8];

    // The buffer address is presented in IDLE so the word is ready during LOAD.
    assign buf_addr   = head_reg[7:2];
    assign queue_head = {24'd0, head_reg};
    assign tx_valid   = tx_valid_reg;
    assign tx_data    = tx_data_reg;
    assign busy       = (state_reg != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            head_reg     <= 8'd0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'd0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        head_next     = head_reg;
        tx_valid_next = tx_valid_reg;
        tx_data_next  = tx_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enable && (head_reg != queue_tail[7:0])) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_next  = select_lane(buf_rdata, head_reg[1:0]);
                tx_valid_next = 1'b1;
                state_next    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_valid_next = 1'b0;
                    head_next     = (head_reg + 8'd1) & HEAD_MASK;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_queue_ctrl.sv
// Scoreboard bench: producer side pushes expected bytes computed from the buffer
// image; a negedge monitor compares every handshake and checks hold/head behaviour.
module tb_uart_tx_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] queue_tail;
    logic [31:0] queue_head;
    logic [5:0]  buf_addr;
    logic [31:0] buf_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;

    uart_tx_queue_ctrl #(.QUEUE_BYTES(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .queue_tail (queue_tail),
        .queue_head (queue_head),
        .buf_addr   (buf_addr),
        .buf_rdata  (buf_rdata),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Buffer memory with one-cycle registered read.
    logic [31:0] mem [64];
    always @(posedge clk) buf_rdata <= mem[buf_addr];

    // Reference model: ring of bytes, indices modulo 256.
    logic [7:0] byte_q [$];
    int         head_model = 0;
    int         tail_model = 0;
    int         checks = 0;
    int         passes = 0;
    int         cycle = 0;
    int         hs_cycles [$];

    always @(posedge clk) cycle++;

    function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    endfunction

    function automatic logic [7:0] ref_byte(int idx);
        logic [31:0] w;
        w = mem[idx / 4];
        return 8'(w >> (8 * (idx % 4)));
    endfunction

    // Monitor
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk(tx_valid === 1'b1, "hold_valid", 32'(tx_valid), 32'd1);
                chk(tx_data === stall_data, "hold_data", 32'(tx_data), 32'(stall_data));
                chk(queue_head === 32'(head_model), "hold_head", queue_head, 32'(head_model));
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (byte_q.size() == 0) begin
                    chk(1'b0, "unexpected_byte", 32'(tx_data), 32'd0);
                end else begin
                    exp_b = byte_q.pop_front();
                    chk(tx_data === exp_b, "tx_data", 32'(tx_data), 32'(exp_b));
                    chk(queue_head === 32'(head_model), "head_at_hs", queue_head, 32'(head_model));
                    chk(buf_addr === 6'(head_model >> 2), "buf_addr", 32'(buf_addr), 32'(head_model >> 2));
                    $display("tx byte %02h head %0d cycle %0d", tx_data, head_model, cycle);
                    head_model = (head_model + 1) % 256;
                    hs_cycles.push_back(cycle);
                end
                stall_prev = 1'b0;
            end else if (tx_valid === 1'b1) begin
                stall_prev = 1'b1;
                stall_data = tx_data;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic advance_tail(int n);
        for (int i = 0; i < n; i++) begin
            byte_q.push_back(ref_byte(tail_model));
            tail_model = (tail_model + 1) % 256;
        end
        queue_tail = ($urandom() & 32'hffff_ff00) | 32'(tail_model);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        queue_tail = 32'd0;
        byte_q.delete();
        head_model = 0;
        tail_model = 0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int k = 0;
        enable   = 1'b1;
        tx_ready = 1'b1;
        while ((byte_q.size() != 0 || busy) && k < budget) begin
            tick(1);
            k++;
        end
        chk(k < budget, "drain_timeout", 32'(byte_q.size()), 32'd0);
    endtask

    task automatic wait_valid(int budget);
        int k = 0;
        while (tx_valid !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        chk(k < budget, "valid_timeout", 32'(tx_valid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom();
        mem[0]     = 32'h4443_4241;
        mem[1]     = 32'h4847_4645;
        rst        = 1'b1;
        enable     = 1'b1;
        tx_ready   = 1'b1;
        queue_tail = 32'd0;
        tick(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk(tx_valid === 1'b0, "rst_valid", 32'(tx_valid), 32'd0);
        chk(queue_head === 32'd0, "rst_head", queue_head, 32'd0);
        chk(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
        chk(tx_data === 8'd0, "rst_data", 32'(tx_data), 32'd0);

        // Single byte: latency of two cycles, valid for exactly one cycle
        tick(1);
        advance_tail(1);
        @(negedge clk);
        chk(busy === 1'b0, "single_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk(busy === 1'b1 && tx_valid === 1'b0, "single_load", {30'd0, busy, tx_valid}, 32'd2);
        @(negedge clk);
        chk(tx_valid === 1'b1, "single_valid", 32'(tx_valid), 32'd1);
        chk(tx_data === 8'h41, "single_data", 32'(tx_data), 32'h41);
        @(negedge clk);
        chk(tx_valid === 1'b0, "single_valid_drop", 32'(tx_valid), 32'd0);
        chk(queue_head === 32'd1, "single_head", queue_head, 32'd1);

        // Burst of four bytes at three-cycle spacing
        tick(1);
        do_reset();
        hs_cycles.delete();
        advance_tail(4);
        wait_drain(100);
        chk(hs_cycles.size() == 4, "burst_count", 32'(hs_cycles.size()), 32'd4);
        for (int i = 1; i < hs_cycles.size(); i++)
            chk(hs_cycles[i] - hs_cycles[i-1] == 3, "burst_spacing",
                32'(hs_cycles[i] - hs_cycles[i-1]), 32'd3);
        chk(queue_head === 32'd4, "burst_head", queue_head, 32'd4);
        chk(busy === 1'b0, "burst_busy", 32'(busy), 32'd0);

        // Backpressure for ten cycles
        tx_ready = 1'b0;
        advance_tail(1);
        wait_valid(20);
        repeat (10) begin
            @(negedge clk);
            chk(tx_valid === 1'b1 && queue_head === 32'd4, "bp_hold",
                queue_head, 32'd4);
        end
        tick(1);
        wait_drain(20);
        chk(queue_head === 32'd5, "bp_head", queue_head, 32'd5);

        // enable low blocks new bytes
        enable = 1'b0;
        advance_tail(3);
        repeat (10) begin
            @(negedge clk);
            chk(tx_valid === 1'b0 && busy === 1'b0, "disabled_idle",
                {30'd0, busy, tx_valid}, 32'd0);
        end
        tick(1);
        wait_drain(50);

        // Random traffic with tail moves mid-flight and toggling enable/ready
        for (int it = 0; it < 600; it++) begin
            tick(1);
            enable   = ($urandom_range(0, 3) != 0);
            tx_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(1, 6);
                if (byte_q.size() + n <= 255) advance_tail(n);
            end
        end
        wait_drain(3000);

        // Wrap from 254 through 255 to 0 and 1
        tick(1);
        if (tail_model != 254) advance_tail((254 - tail_model + 256) % 256);
        wait_drain(1000);
        chk(queue_head === 32'd254, "wrap_start", queue_head, 32'd254);
        mem[63] = 32'haabb_ccdd;
        mem[0]  = 32'h4443_4241;
        advance_tail(3);
        wait_drain(50);
        chk(queue_head === 32'd1, "wrap_head", queue_head, 32'd1);

        // Reset while a byte is held in SEND
        tx_ready = 1'b0;
        advance_tail(2);
        wait_valid(20);
        do_reset();
        @(negedge clk);
        chk(tx_valid === 1'b0, "rst_send_valid", 32'(tx_valid), 32'd0);
        chk(queue_head === 32'd0, "rst_send_head", queue_head, 32'd0);
        chk(busy === 1'b0, "rst_send_busy", 32'(busy), 32'd0);
        tick(5);
        chk(tx_valid === 1'b0 && busy === 1'b0, "post_rst_idle", {30'd0, busy, tx_valid}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
